// File: rtl/aibcr3_dll_codectl.sv
// ---------------------------------------------------------------------------
// aibcr3_dll_codectl
//   Delay-code controller for a 64-cell DLL delay line. Phase-detector votes
//   are filtered by a signed accumulator; each full filter window moves the
//   delay code by one. Direction reversals are counted to declare lock.
//   An override path forces the code directly.
//
// Ports
//   CLKIN      in   1   sole clock, rising edge
//   RSTb       in   1   async active-low reset (release synchronised inside)
//   enable     in   1   1 = tracking allowed, 0 = hold in IDLE
//   pd_vld     in   1   phase-detector sample strobe
//   pd_up      in   1   1 = vote up (delay too short), 0 = vote down
//   ovrd_en    in   1   force code to ovrd_code (highest priority)
//   ovrd_code  in   6   override code
//   code_out   out  6   registered delay code
//   bk         out 64   registered thermometer tap word, bk[i] = (i <= code)
//   lock       out  1   registered lock flag
//   sat_hi     out  1   up step requested at code 63
//   sat_lo     out  1   down step requested at code 0
//
// state  | meaning
// IDLE   | tracking disabled, code held, filter/reversals/flags cleared
// TRACK  | filtering votes and stepping the code, not yet locked
// LOCKED | stepping continues, lock asserted until two same-direction steps
// OVRD   | code follows ovrd_code every cycle
// ---------------------------------------------------------------------------
module aibcr3_dll_codectl #(
    parameter int         FILT_TH   = 4,
    parameter int         LOCK_REV  = 3,
    parameter logic [5:0] INIT_CODE = 6'd32
) (
    input  logic        CLKIN,
    input  logic        RSTb,
    input  logic        enable,
    input  logic        pd_vld,
    input  logic        pd_up,
    input  logic        ovrd_en,
    input  logic [5:0]  ovrd_code,
    output logic [5:0]  code_out,
    output logic [63:0] bk,
    output logic        lock,
    output logic        sat_hi,
    output logic        sat_lo
);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED, OVRD} state_t;

    localparam logic signed [3:0] ACC_MAX    = 4'(FILT_TH - 1);
    localparam logic signed [3:0] ACC_MIN    = -ACC_MAX;
    localparam logic [3:0]        LOCK_REV_W = 4'(LOCK_REV);

    function automatic logic [63:0] therm(input logic [5:0] c);
        logic [63:0] t;
        for (int i = 0; i < 64; i++) begin
            t[i] = (6'(i) <= c);
        end
        return t;
    endfunction

    // Assertion propagates asynchronously; release is retimed to CLKIN.
    logic [1:0] rst_sync;
    logic       rst_b;

    always_ff @(posedge CLKIN or negedge RSTb) begin
        if (!RSTb) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_b = rst_sync[1];

    state_t            state, state_nxt;
    logic [5:0]        code_nxt;
    logic [63:0]       bk_nxt;
    logic signed [3:0] acc, acc_nxt;
    logic [3:0]        rev_cnt, rev_nxt;
    logic              dir_vld, dir_vld_nxt;
    logic              dir_up, dir_up_nxt;
    logic              lock_nxt, sat_hi_nxt, sat_lo_nxt;
    logic              applied, applied_up;

    always_comb begin
        state_nxt   = state;
        code_nxt    = code_out;
        acc_nxt     = acc;
        rev_nxt     = rev_cnt;
        dir_vld_nxt = dir_vld;
        dir_up_nxt  = dir_up;
        lock_nxt    = lock;
        sat_hi_nxt  = sat_hi;
        sat_lo_nxt  = sat_lo;
        applied     = 1'b0;
        applied_up  = 1'b0;

        if (ovrd_en) begin
            state_nxt   = OVRD;
            code_nxt    = ovrd_code;
            acc_nxt     = '0;
            rev_nxt     = '0;
            dir_vld_nxt = 1'b0;
            lock_nxt    = 1'b0;
            sat_hi_nxt  = 1'b0;
            sat_lo_nxt  = 1'b0;
        end else if (state == OVRD) begin
            state_nxt = enable ? TRACK : IDLE;
        end else if (!enable) begin
            state_nxt   = IDLE;
            acc_nxt     = '0;
            rev_nxt     = '0;
            dir_vld_nxt = 1'b0;
            lock_nxt    = 1'b0;
            sat_hi_nxt  = 1'b0;
            sat_lo_nxt  = 1'b0;
        end else if (state == IDLE) begin
            state_nxt = TRACK;
        end else if (pd_vld) begin
            if (pd_up) begin
                if (acc == ACC_MAX) begin
                    acc_nxt = '0;
                    if (code_out == 6'd63) begin
                        sat_hi_nxt = 1'b1;
                    end else begin
                        code_nxt   = code_out + 6'd1;
                        sat_lo_nxt = 1'b0;
                        applied    = 1'b1;
                        applied_up = 1'b1;
                    end
                end else begin
                    acc_nxt = acc + 4'sd1;
                end
            end else begin
                if (acc == ACC_MIN) begin
                    acc_nxt = '0;
                    if (code_out == 6'd0) begin
                        sat_lo_nxt = 1'b1;
                    end else begin
                        code_nxt   = code_out - 6'd1;
                        sat_hi_nxt = 1'b0;
                        applied    = 1'b1;
                    end
                end else begin
                    acc_nxt = acc - 4'sd1;
                end
            end

            // Saturated requests never reach here, so they neither count as
            // reversals nor break lock.
            if (applied) begin
                dir_vld_nxt = 1'b1;
                dir_up_nxt  = applied_up;
                if (dir_vld && (dir_up != applied_up)) begin
                    rev_nxt = (rev_cnt == 4'hF) ? rev_cnt : rev_cnt + 4'd1;
                    if ((state == TRACK) && (rev_nxt >= LOCK_REV_W)) begin
                        state_nxt = LOCKED;
                        lock_nxt  = 1'b1;
                    end
                end else if (dir_vld && (state == LOCKED)) begin
                    state_nxt = TRACK;
                    lock_nxt  = 1'b0;
                    rev_nxt   = '0;
                end
            end
        end

        bk_nxt = therm(code_nxt);
    end

    always_ff @(posedge CLKIN or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            code_out <= INIT_CODE;
            bk       <= therm(INIT_CODE);
            acc      <= '0;
            rev_cnt  <= '0;
            dir_vld  <= 1'b0;
            dir_up   <= 1'b0;
            lock     <= 1'b0;
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b0;
        end else begin
            state    <= state_nxt;
            code_out <= code_nxt;
            bk       <= bk_nxt;
            acc      <= acc_nxt;
            rev_cnt  <= rev_nxt;
            dir_vld  <= dir_vld_nxt;
            dir_up   <= dir_up_nxt;
            lock     <= lock_nxt;
            sat_hi   <= sat_hi_nxt;
            sat_lo   <= sat_lo_nxt;
        end
    end

endmodule

// File: tb/tb_aibcr3_dll_codectl.sv
module tb_aibcr3_dll_codectl;

    localparam int FILT_TH  = 4;
    localparam int LOCK_REV = 3;

    logic        CLKIN = 1'b0;
    logic        RSTb = 1'b0;
    logic        enable = 1'b0;
    logic        pd_vld = 1'b0;
    logic        pd_up = 1'b0;
    logic        ovrd_en = 1'b0;
    logic [5:0]  ovrd_code = 6'd0;
    logic [5:0]  code_out;
    logic [63:0] bk;
    logic        lock, sat_hi, sat_lo;

    always #5 CLKIN = ~CLKIN;

    aibcr3_dll_codectl #(.FILT_TH(FILT_TH), .LOCK_REV(LOCK_REV), .INIT_CODE(6'd32)) dut (
        .CLKIN(CLKIN), .RSTb(RSTb), .enable(enable), .pd_vld(pd_vld), .pd_up(pd_up),
        .ovrd_en(ovrd_en), .ovrd_code(ovrd_code), .code_out(code_out), .bk(bk),
        .lock(lock), .sat_hi(sat_hi), .sat_lo(sat_lo)
    );

    typedef struct {
        int          cyc;
        logic [5:0]  code;
        logic [63:0] bk;
        logic        lock;
        logic        sat_hi;
        logic        sat_lo;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge CLKIN) cyc <= cyc + 1;

    // Reference model: 0 idle, 1 track, 2 locked, 3 override
    int m_mode, m_code, m_acc, m_rev, m_last;
    bit m_lock, m_shi, m_slo;

    function automatic logic [63:0] therm_ref(input int c);
        if (c >= 63) return {64{1'b1}};
        return (64'd1 << (c + 1)) - 64'd1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_code = 32; m_acc = 0; m_rev = 0; m_last = 0;
        m_lock = 0; m_shi = 0; m_slo = 0;
    endfunction

    function automatic void model_apply(input int d);
        if (m_last != 0 && d != m_last) begin
            m_rev++;
            if (m_mode == 1 && m_rev >= LOCK_REV) begin
                m_mode = 2; m_lock = 1;
            end
        end else if (m_last == d && m_mode == 2) begin
            m_mode = 1; m_lock = 0; m_rev = 0;
        end
        m_last = d;
    endfunction

    function automatic void model_edge(input bit en, input bit vld, input bit up,
                                       input bit ov, input int oc);
        if (ov) begin
            m_mode = 3; m_code = oc; m_acc = 0; m_rev = 0; m_last = 0;
            m_lock = 0; m_shi = 0; m_slo = 0;
        end else if (m_mode == 3) begin
            m_mode = en ? 1 : 0;
        end else if (!en) begin
            m_mode = 0; m_acc = 0; m_rev = 0; m_last = 0;
            m_lock = 0; m_shi = 0; m_slo = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (vld) begin
            m_acc += up ? 1 : -1;
            if (m_acc == FILT_TH) begin
                m_acc = 0;
                if (m_code == 63) m_shi = 1;
                else begin m_code++; m_slo = 0; model_apply(1); end
            end else if (m_acc == -FILT_TH) begin
                m_acc = 0;
                if (m_code == 0) m_slo = 1;
                else begin m_code--; m_shi = 0; model_apply(-1); end
            end
        end
    endfunction

    task automatic step(input bit en, input bit vld, input bit up, input bit ov, input int oc);
        exp_t e;
        @(posedge CLKIN);
        #1;
        enable = en; pd_vld = vld; pd_up = up; ovrd_en = ov; ovrd_code = 6'(oc);
        model_edge(en, vld, up, ov, oc);
        e.cyc = cyc + 1;
        e.code = 6'(m_code);
        e.bk = therm_ref(m_code);
        e.lock = m_lock;
        e.sat_hi = m_shi;
        e.sat_lo = m_slo;
        sbq.push_back(e);
    endtask

    // Monitor: compares DUT outputs against the entry scheduled for this cycle.
    always @(negedge CLKIN) begin
        if (RSTb) begin
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                exp_t s;
                s = sbq.pop_front();
                checks++;
                failures++;
                $display("FAIL stale_entry actual_cycle=%0d required_cycle=%0d", cyc, s.cyc);
            end
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_code", code_out, e.code);
                chk("sb_bk", bk, e.bk);
                chk("sb_lock", lock, e.lock);
                chk("sb_sat_hi", sat_hi, e.sat_hi);
                chk("sb_sat_lo", sat_lo, e.sat_lo);
            end
        end
    end

    task automatic votes(input int n, input bit up);
        for (int i = 0; i < n; i++) step(1, 1, up, 0, 0);
    endtask

    initial begin
        int tgt;
        model_reset();

        #22;
        chk("rst_code", code_out, 6'd32);
        chk("rst_bk", bk, 64'h0000_0001_FFFF_FFFF);
        chk("rst_lock", lock, 1'b0);
        chk("rst_sat_hi", sat_hi, 1'b0);
        chk("rst_sat_lo", sat_lo, 1'b0);
        RSTb = 1'b1;
        repeat (3) step(0, 0, 0, 0, 0);

        // Up step
        step(1, 0, 0, 0, 0);
        votes(4, 1);
        step(1, 0, 0, 0, 0);
        chk("up_code", code_out, 6'd33);
        chk("up_bk33", bk[33], 1'b1);
        chk("up_bk34", bk[34], 1'b0);

        // Alternating steps toward lock
        votes(4, 0);
        votes(4, 1);
        votes(4, 0);
        step(1, 0, 0, 0, 0);
        chk("lock_code", code_out, 6'd32);
        chk("lock_flag", lock, 1'b1);

        // Partial filter window, then async reset while locked
        votes(3, 1);
        #2;
        RSTb = 1'b0;
        #1;
        chk("arst_code", code_out, 6'd32);
        chk("arst_bk", bk, 64'h0000_0001_FFFF_FFFF);
        chk("arst_lock", lock, 1'b0);
        chk("arst_sat", {sat_hi, sat_lo}, 2'b00);
        sbq.delete();
        model_reset();
        #7;
        RSTb = 1'b1;
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        votes(1, 1);
        step(1, 0, 0, 0, 0);
        chk("discard_code", code_out, 6'd32);

        // Override priority over votes
        for (int i = 0; i < 6; i++) step(1, 1'($urandom), 1'($urandom), 1, 5);
        step(1, 1, 1, 1, 5);
        chk("ovrd_code", code_out, 6'd5);
        chk("ovrd_bk", bk, 64'h3F);
        chk("ovrd_lock", lock, 1'b0);

        // Saturation high
        step(1, 0, 0, 1, 63);
        step(1, 0, 0, 0, 0);
        votes(4, 1);
        step(1, 0, 0, 0, 0);
        chk("sathi_code", code_out, 6'd63);
        chk("sathi_flag", sat_hi, 1'b1);
        votes(4, 0);
        step(1, 0, 0, 0, 0);
        chk("sathi_clr_code", code_out, 6'd62);
        chk("sathi_clr_flag", sat_hi, 1'b0);

        // Saturation low, then disable clears flags
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        votes(4, 0);
        step(1, 0, 0, 0, 0);
        chk("satlo_code", code_out, 6'd0);
        chk("satlo_bk", bk, 64'h1);
        chk("satlo_flag", sat_lo, 1'b1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("idle_satlo", sat_lo, 1'b0);
        chk("idle_code", code_out, 6'd0);

        // Randomized tracking toward a moving target
        tgt = 40;
        for (int n = 0; n < 4000; n++) begin
            bit en, ov, vld, up;
            int oc, r;
            if (n % 300 == 0) begin
                r = $urandom_range(0, 5);
                tgt = (r == 0) ? 0 : (r == 1) ? 63 : $urandom_range(0, 63);
            end
            en  = ($urandom % 50) != 0;
            ov  = ($urandom % 80) == 0;
            vld = ($urandom % 3) != 0;
            r = $urandom_range(0, 3);
            oc = (r == 0) ? 0 : (r == 1) ? 63 : $urandom_range(0, 63);
            if ($urandom % 8 == 0) up = 1'($urandom);
            else if (m_code < tgt) up = 1;
            else if (m_code > tgt) up = 0;
            else up = 1'($urandom);
            step(en, vld, up, ov, oc);
        end

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge CLKIN);
        @(negedge CLKIN);
        #1;
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual_pending=%0d required_pending=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
